// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Registered program counter with next-PC selection (sequential,
//            branch, region jump, register jump) and a circular return stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                IMM_W     = 16,
    parameter int                TGT_W     = 26,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [1:0]                   pc_mode,
    input  logic                         branch_taken,
    input  logic [IMM_W-1:0]             imm,
    input  logic [TGT_W-1:0]             target,
    input  logic [ADDR_W-1:0]            reg_addr,
    input  logic                         link,
    input  logic                         ret,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_4,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         misalign
);

    localparam int                c_PTR_W = $clog2(RAS_DEPTH);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RAS_DEPTH);

    localparam logic [1:0] c_MODE_SEQ = 2'b00;
    localparam logic [1:0] c_MODE_BR  = 2'b01;
    localparam logic [1:0] c_MODE_JMP = 2'b10;
    localparam logic [1:0] c_MODE_JR  = 2'b11;

    logic [ADDR_W-1:0]  r_pc;
    logic [c_PTR_W-1:0] r_wp;
    logic [c_CNT_W-1:0] r_count;
    logic               r_misalign;
    logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];

    logic [ADDR_W-1:0]  w_pc_4;
    logic [ADDR_W-1:0]  w_br_off;
    logic [ADDR_W-1:0]  w_jump_addr;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_push;
    logic               w_pop;
    logic               w_misalign_next;

    assign w_pc_4    = r_pc + ADDR_W'(4);
    assign w_br_off  = {{(ADDR_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    // wp points at the next free slot, so the top of stack sits one below it
    assign w_top_idx = r_wp - c_PTR_W'(1);

    generate
        if (ADDR_W > TGT_W + 2) begin : g_region
            assign w_jump_addr = {w_pc_4[ADDR_W-1:TGT_W+2], target, 2'b00};
        end else begin : g_no_region
            assign w_jump_addr = {target, 2'b00};
        end
    endgenerate

    always_comb begin
        w_push          = link && pc_mode[1];
        w_pop           = (pc_mode == c_MODE_JR) && ret && (r_count != '0);
        w_misalign_next = 1'b0;
        w_pc_next       = w_pc_4;
        case (pc_mode)
            c_MODE_SEQ: w_pc_next = w_pc_4;
            c_MODE_BR:  w_pc_next = branch_taken ? (w_pc_4 + w_br_off) : w_pc_4;
            c_MODE_JMP: w_pc_next = w_jump_addr;
            c_MODE_JR: begin
                if (w_pop) begin
                    w_pc_next = r_ras[w_top_idx];
                end else begin
                    w_pc_next       = {reg_addr[ADDR_W-1:2], 2'b00};
                    w_misalign_next = (reg_addr[1:0] != 2'b00);
                end
            end
            default: w_pc_next = w_pc_4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_wp       <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
            if (w_push && !w_pop) begin
                // a push onto a full stack silently drops the oldest entry
                r_wp <= r_wp + c_PTR_W'(1);
                if (r_count != c_DEPTH) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end else if (w_pop && !w_push) begin
                r_wp    <= w_top_idx;
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Stack storage carries no reset; pointers alone define validity
    always_ff @(posedge clk) begin
        if (rst_n && !stall && w_push) begin
            if (w_pop) begin
                r_ras[w_top_idx] <= w_pc_4;
            end else begin
                r_ras[r_wp] <= w_pc_4;
            end
        end
    end

    assign pc        = r_pc;
    assign pc_4      = w_pc_4;
    assign ras_count = r_count;
    assign ras_empty = (r_count == '0);
    assign ras_full  = (r_count == c_DEPTH);
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed bench for pc_sequencer with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] c_RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall = 1'b0;
    logic [1:0]  pc_mode = 2'b00;
    logic        branch_taken = 1'b0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic [31:0] reg_addr = '0;
    logic        link = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign;

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 1'b0;

    pc_sequencer #(
        .ADDR_W   (32),
        .IMM_W    (16),
        .TGT_W    (26),
        .RAS_DEPTH(4),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc_mode     (pc_mode),
        .branch_taken(branch_taken),
        .imm         (imm),
        .target      (target),
        .reg_addr    (reg_addr),
        .link        (link),
        .ret         (ret),
        .pc          (pc),
        .pc_4        (pc_4),
        .ras_count   (ras_count),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    // Reference model: PC as a plain number, return stack as a bounded queue
    logic [31:0] m_pc  = c_RESET_PC;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc  = c_RESET_PC;
            m_mis = 1'b0;
            m_ras.delete();
        end else if (!stall) begin
            logic [31:0] seq;
            logic [31:0] nxt;
            bit          do_pop;
            bit          do_push;
            int          off;
            seq     = m_pc + 32'd4;
            do_pop  = (pc_mode == 2'd3) && ret && (m_ras.size() > 0);
            do_push = link && (pc_mode >= 2'd2);
            off     = $signed(imm);
            m_mis   = 1'b0;
            case (pc_mode)
                2'd0: nxt = seq;
                2'd1: nxt = branch_taken ? seq + 32'(off * 4) : seq;
                2'd2: nxt = (seq & 32'hF000_0000) | (32'(target) * 32'd4);
                default: begin
                    if (do_pop) nxt = m_ras[$];
                    else begin
                        nxt   = reg_addr & ~32'd3;
                        m_mis = (reg_addr % 4) != 0;
                    end
                end
            endcase
            if (do_push && do_pop) m_ras[$] = seq;
            else if (do_pop) void'(m_ras.pop_back());
            else if (do_push) begin
                if (m_ras.size() == 4) void'(m_ras.pop_front());
                m_ras.push_back(seq);
            end
            m_pc = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pc", pc, m_pc);
            chk("model_pc_4", pc_4, m_pc + 32'd4);
            chk("model_ras_count", 32'(ras_count), 32'(m_ras.size()));
            chk("model_ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            chk("model_ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
            chk("model_misalign", 32'(misalign), 32'(m_mis));
        end
    end

    task automatic step(input logic [1:0] md, input logic tk, input logic [15:0] im,
                        input logic [25:0] tg, input logic [31:0] ra,
                        input logic lk, input logic rt, input logic st);
        @(negedge clk);
        #1;
        pc_mode = md; branch_taken = tk; imm = im; target = tg;
        reg_addr = ra; link = lk; ret = rt; stall = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        #1;
        chk("reset_pc", pc, 32'h0040_0000);
        chk("reset_count", 32'(ras_count), 32'd0);
        chk("reset_empty", 32'(ras_empty), 32'd1);
        chk("reset_full", 32'(ras_full), 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);

        // Sequential run out of reset
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("seq1", pc, 32'h0040_0004);
        step(2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 0);
        chk("seq2", pc, 32'h0040_0008);
        step(2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 0);
        chk("seq3", pc, 32'h0040_000C);

        // Asynchronous reset mid-run
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pc", pc, 32'h0040_0000);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Branches
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_1000, 0, 0, 0);
        chk("jr_setup", pc, 32'h0000_1000);
        step(2'd1, 1, 16'hFFFF, 26'h0, 32'h0, 0, 0, 0);
        chk("branch_neg", pc, 32'h0000_1000);
        step(2'd1, 1, 16'h0010, 26'h0, 32'h0, 1, 1, 0);
        chk("branch_pos", pc, 32'h0000_1044);
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_1000, 0, 0, 0);
        step(2'd1, 0, 16'h0010, 26'h0, 32'h0, 0, 0, 0);
        chk("branch_not_taken", pc, 32'h0000_1004);

        // Region jump and wrap
        step(2'd3, 0, 16'h0, 26'h0, 32'hF000_0010, 0, 0, 0);
        step(2'd2, 0, 16'h0, 26'h000_0100, 32'h0, 0, 0, 0);
        chk("jump_region", pc, 32'hF000_0400);
        step(2'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, 0, 0, 0);
        step(2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 0);
        chk("pc_wrap", pc, 32'h0000_0000);

        // Misaligned register jump
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_2003, 0, 0, 0);
        chk("jr_misalign_pc", pc, 32'h0000_2000);
        chk("jr_misalign_flag", 32'(misalign), 32'd1);
        step(2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 0);
        chk("misalign_clears", 32'(misalign), 32'd0);

        // Five linked jumps from 0x2004, 0x2100, 0x2200, 0x2300, 0x2400
        for (int i = 0; i < 5; i++) begin
            step(2'd3, 0, 16'h0, 26'h0, 32'h0000_2100 + 32'(i) * 32'h100, 1, 0, 0);
        end
        chk("ras_full_flag", 32'(ras_full), 32'd1);
        chk("ras_full_count", 32'(ras_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(2'd3, 0, 16'h0, 26'h0, 32'h0000_3000, 0, 1, 0);
            chk("ras_return", pc, 32'h0000_2404 - 32'(i) * 32'h100);
        end
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_3000, 0, 1, 0);
        chk("ras_empty_fallback", pc, 32'h0000_3000);
        chk("ras_empty_flag", 32'(ras_empty), 32'd1);

        // Stall, then simultaneous push/pop
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_0100, 0, 0, 0);
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_0500, 1, 0, 0);
        step(2'd2, 0, 16'h0, 26'h0000_0AA, 32'h0, 1, 0, 1);
        chk("stall_pc", pc, 32'h0000_0500);
        chk("stall_count", 32'(ras_count), 32'd1);
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_9000, 1, 1, 0);
        chk("pushpop_pc", pc, 32'h0000_0104);
        chk("pushpop_count", 32'(ras_count), 32'd1);
        step(2'd3, 0, 16'h0, 26'h0, 32'h0000_7000, 0, 1, 0);
        chk("pushpop_return", pc, 32'h0000_0504);
        step(2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 0);

        @(negedge clk); #1;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
